// File: rtl/timer_pkg.sv
// Shared definitions for the kitchen-timer front end: command word layout,
// button channel states and the reset-request pulse priority rule.
package timer_pkg;

  localparam int unsigned CMD_W = 13;
  localparam int unsigned BTN_W = 3;
  localparam int unsigned SW_W  = 10;
  localparam int unsigned SET_W = 6;

  localparam int unsigned START   = 12;
  localparam int unsigned RST_REQ = 11;
  localparam int unsigned PAUSE   = 10;
  localparam int unsigned UPDN    = 9;
  localparam int unsigned FAST    = 8;
  localparam int unsigned MIN     = 7;
  localparam int unsigned SEC     = 6;
  localparam int unsigned SET_LSB = 0;
  localparam int unsigned SET_MSB = 5;

  // Button positions inside btn_raw
  localparam int unsigned BTN_START = 2;
  localparam int unsigned BTN_RST   = 1;
  localparam int unsigned BTN_PAUSE = 0;

  typedef enum logic [1:0] {
    BTN_DISARMED = 2'd0,
    BTN_ARMED    = 2'd1,
    BTN_PRESSED  = 2'd2
  } btn_state_e;

  // A reset request wins over start and pause in the same cycle.
  function automatic logic [BTN_W-1:0] mask_pulses(input logic [BTN_W-1:0] rise);
    logic [BTN_W-1:0] masked;
    masked = rise;
    if (rise[BTN_RST]) begin
      masked[BTN_START] = 1'b0;
      masked[BTN_PAUSE] = 1'b0;
    end
    return masked;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input line: 2-flop synchronizer followed by a counting debouncer that
// accepts a new level only after it has persisted for DEBOUNCE_CYCLES cycles.
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic synced,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the stable level restarts the count.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign synced = sync2_q;
  assign stable = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Board buttons/switches to timer command word: 13 debounced channels, button
// press pulses with reset-request priority, and a set-time change strobe.
module input_conditioner
  import timer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  btn_raw,
  input  logic [9:0]  sw_raw,
  output logic [12:0] cmd,
  output logic        set_strobe
);

  logic [CMD_W-1:0] raw_all;
  logic [CMD_W-1:0] synced_all;
  logic [CMD_W-1:0] stable_all;

  assign raw_all = {btn_raw, sw_raw};

  for (genvar i = 0; i < CMD_W; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_all[i]),
      .synced(synced_all[i]),
      .stable(stable_all[i])
    );
  end

  logic [BTN_W-1:0] btn_stable;
  logic [BTN_W-1:0] btn_synced;
  logic [SW_W-1:0]  sw_stable;
  logic [SW_W-1:0]  sw_synced_unused;

  assign btn_stable       = stable_all[CMD_W-1:SW_W];
  assign btn_synced       = synced_all[CMD_W-1:SW_W];
  assign sw_stable        = stable_all[SW_W-1:0];
  assign sw_synced_unused = synced_all[SW_W-1:0];

  btn_state_e       btn_state_q [BTN_W];
  btn_state_e       btn_state_d [BTN_W];
  logic [1:0]       sync_ok_q, sync_ok_d;
  logic [BTN_W-1:0] rise_c;
  logic [BTN_W-1:0] pulse_q, pulse_d;
  logic [SET_W-1:0] prev_set_q, prev_set_d;
  logic             strobe_q, strobe_d;

  // Synchronizers hold reset zeros for two cycles after reset; a button only
  // arms once a real sample confirms it is released, so a button held through
  // reset never fires until it is released and pressed again.
  always_comb begin
    sync_ok_d = {sync_ok_q[0], 1'b1};
    rise_c    = '0;
    for (int b = 0; b < int'(BTN_W); b++) begin
      btn_state_d[b] = btn_state_q[b];
      case (btn_state_q[b])
        BTN_DISARMED: begin
          if (sync_ok_q[1] && !btn_stable[b] && !btn_synced[b]) begin
            btn_state_d[b] = BTN_ARMED;
          end
        end
        BTN_ARMED: begin
          if (btn_stable[b]) begin
            btn_state_d[b] = BTN_PRESSED;
            rise_c[b]      = 1'b1;
          end
        end
        BTN_PRESSED: begin
          if (!btn_stable[b]) begin
            btn_state_d[b] = BTN_ARMED;
          end
        end
        default: btn_state_d[b] = BTN_DISARMED;
      endcase
    end
    pulse_d    = mask_pulses(rise_c);
    prev_set_d = sw_stable[SET_MSB:SET_LSB];
    strobe_d   = (prev_set_q != sw_stable[SET_MSB:SET_LSB]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ok_q  <= '0;
      pulse_q    <= '0;
      prev_set_q <= '0;
      strobe_q   <= 1'b0;
      for (int b = 0; b < int'(BTN_W); b++) begin
        btn_state_q[b] <= BTN_DISARMED;
      end
    end else begin
      sync_ok_q  <= sync_ok_d;
      pulse_q    <= pulse_d;
      prev_set_q <= prev_set_d;
      strobe_q   <= strobe_d;
      for (int b = 0; b < int'(BTN_W); b++) begin
        btn_state_q[b] <= btn_state_d[b];
      end
    end
  end

  assign cmd[START]           = pulse_q[BTN_START];
  assign cmd[RST_REQ]         = pulse_q[BTN_RST];
  assign cmd[PAUSE]           = pulse_q[BTN_PAUSE];
  assign cmd[UPDN]            = sw_stable[UPDN];
  assign cmd[FAST]            = sw_stable[FAST];
  assign cmd[MIN]             = sw_stable[MIN];
  assign cmd[SEC]             = sw_stable[SEC];
  assign cmd[SET_MSB:SET_LSB] = sw_stable[SET_MSB:SET_LSB];
  assign set_strobe           = strobe_q;

endmodule
